// File: rtl/time_display_pkg.sv
// Shared constants and types for the six-digit multiplexed time display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package time_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [2:0] digit_idx_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SEC  = 2'd1,
        MIN  = 2'd2,
        HOUR = 2'd3
    } field_sel_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/time_display_bin2bcd8.sv
// Combinational split of an 8-bit field into two BCD digits.
// Values of 100 or more raise overflow; tens/units are then meaningless.
module bin2bcd8 (
    input  logic [7:0] value,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       overflow
);

    logic [7:0] quotient;

    assign quotient = value / 8'd10;
    assign tens     = quotient[3:0];
    assign units    = 4'(value - 8'(quotient * 8'd10));
    assign overflow = quotient >= 8'd10;

endmodule

// File: rtl/time_display.sv
// Six-digit seven-segment scanner for the {hours, minutes, seconds} time word.
// Build option TIME_DISPLAY_BLINK_EN blinks the field under edit; otherwise its dp is lit.
module time_display
    import time_display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] data,
    input  logic [23:0] setup_data,
    input  logic [1:0]  setup_rezhim,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  dig
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_bad_params
        $error("time_display: SCAN_DIV and BLINK_DIV must be at least 2");
    end

    logic [SW-1:0] prescale;
    logic          scan_tick;
    digit_idx_t    slot;
    logic [23:0]   frame;
    logic [23:0]   source;
    logic [23:0]   frame_view;
    logic [1:0]    field;
    logic [7:0]    field_val;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic          overflow;
    logic          edited;
    logic          separator;
    logic          dig_off;
    logic          dp_next;
    logic [6:0]    seg_next;
    logic [5:0]    dig_next;
    field_sel_e    mode;

    assign mode      = field_sel_e'(setup_rezhim);
    assign scan_tick = (prescale == SCAN_LAST);
    assign source    = (mode != RUN) ? setup_data : data;
    // Slot 0 is loaded on the same edge as the frame, so it reads the source directly.
    assign frame_view = (slot == 3'd0) ? source : frame;
    assign field      = slot[2:1];

    always_comb begin
        field_val = frame_view[23:16];
        case (field)
            2'd0:    field_val = frame_view[7:0];
            2'd1:    field_val = frame_view[15:8];
            default: field_val = frame_view[23:16];
        endcase
    end

    bin2bcd8 u_bcd (
        .value    (field_val),
        .tens     (tens),
        .units    (units),
        .overflow (overflow)
    );

    assign edited    = (mode != RUN) && (field == (setup_rezhim - 2'd1));
    assign separator = (slot == 3'd2) || (slot == 3'd4);
    assign seg_next  = overflow ? SEG_DASH : seg_encode(slot[0] ? tens : units);
    assign dig_next  = dig_off ? 6'h3F : ~(6'd1 << slot);

`ifdef TIME_DISPLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          blink_next;
    logic [1:0]    prev_rezhim;
    logic          rezhim_changed;

    assign rezhim_changed = (setup_rezhim != prev_rezhim);
    // The digit loaded on a toggle edge must already see the new phase.
    assign blink_next = (rezhim_changed || mode == RUN) ? 1'b0 :
                        (blink_cnt == BLINK_LAST) ? ~blink_phase : blink_phase;
    assign dig_off    = edited && blink_next;
    assign dp_next    = ~separator;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            prev_rezhim <= 2'd0;
        end else begin
            prev_rezhim <= setup_rezhim;
            blink_phase <= blink_next;
            if (rezhim_changed || mode == RUN || blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign dig_off = 1'b0;
    assign dp_next = ~(separator || edited);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            slot     <= 3'd0;
            frame    <= 24'd0;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
            dig      <= 6'h3F;
        end else if (scan_tick) begin
            prescale <= '0;
            slot     <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
            if (slot == 3'd0) begin
                frame <= source;
            end
            seg <= seg_next;
            dp  <= dp_next;
            dig <= dig_next;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Bench for time_display: constant vector table, hand sequences, and a random run
// checked every cycle against an arithmetic model of the scan/blink behaviour.
module tb_time_display;

    localparam int SCAN  = 4;
    localparam int BLINK = 32;

    logic        clock;
    logic        reset;
    logic [23:0] data;
    logic [23:0] setup_data;
    logic [1:0]  setup_rezhim;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  dig;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 0;

    time_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clock        (clock),
        .reset        (reset),
        .data         (data),
        .setup_data   (setup_data),
        .setup_rezhim (setup_rezhim),
        .seg          (seg),
        .dp           (dp),
        .dig          (dig)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] digit_code(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int s, input logic [23:0] f);
        logic [23:0] sh;
        int v;
        sh = f >> (8 * (s / 2));
        v = int'(sh[7:0]);
        if (v >= 100) return 7'h3F;
        return digit_code((s % 2 == 1) ? v / 10 : v % 10);
    endfunction

    function automatic logic exp_dp(input int s, input int mode);
        logic lit;
        lit = (s == 2) || (s == 4);
`ifndef TIME_DISPLAY_BLINK_EN
        if (mode != 0 && s / 2 == mode - 1) lit = 1'b1;
`endif
        return ~lit;
    endfunction

    function automatic logic [5:0] exp_dig(input int s, input int mode, input logic phase);
`ifdef TIME_DISPLAY_BLINK_EN
        if (phase && mode != 0 && s / 2 == mode - 1) return 6'h3F;
`endif
        return ~(6'd1 << s);
    endfunction

    // Reference model: time is counted in edges since reset release, blink phase
    // in edges since the selector last changed.
    int          edge_n, since, m_slot, m_ticks;
    logic [1:0]  last_mode;
    logic [23:0] m_frame;
    logic [6:0]  m_seg;
    logic        m_dp;
    logic [5:0]  m_dig;
    int          next_edge, next_since, next_slot;
    logic [23:0] src_now;
    logic        phase_now;

    assign next_edge  = edge_n + 1;
    assign next_since = (setup_rezhim != last_mode) ? 0 : since + 1;
    assign next_slot  = (next_edge / SCAN - 1) % 6;
    assign src_now    = (setup_rezhim != 2'd0) ? setup_data : data;
    assign phase_now  = (setup_rezhim != 2'd0) && (((next_since / BLINK) % 2) == 1);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_n    <= 0;
            since     <= 0;
            last_mode <= 2'd0;
            m_frame   <= 24'd0;
            m_seg     <= 7'h7F;
            m_dp      <= 1'b1;
            m_dig     <= 6'h3F;
            m_slot    <= -1;
        end else begin
            edge_n    <= next_edge;
            since     <= next_since;
            last_mode <= setup_rezhim;
            if (next_edge % SCAN == 0) begin
                if (next_slot == 0) m_frame <= src_now;
                m_seg   <= exp_seg(next_slot, (next_slot == 0) ? src_now : m_frame);
                m_dp    <= exp_dp(next_slot, int'(setup_rezhim));
                m_dig   <= exp_dig(next_slot, int'(setup_rezhim), phase_now);
                m_slot  <= next_slot;
                m_ticks <= m_ticks + 1;
            end
        end
    end

    task automatic check_output(input string name, input logic [6:0] es,
                                input logic edp, input logic [5:0] edig);
        vectors++;
        if (seg !== es || dp !== edp || dig !== edig) begin
            miscompares++;
            $display("[TB] FAIL %s: got seg=%h dp=%b dig=%h, expected seg=%h dp=%b dig=%h",
                     name, seg, dp, dig, es, edp, edig);
        end
    endtask

    task automatic report_timeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting for a scan tick", name);
    endtask

    always @(negedge clock) begin
        if (check_en) check_output("model", m_seg, m_dp, m_dig);
    end

    task automatic wait_tick();
        int start;
        start = m_ticks;
        for (int i = 0; i < 3 * SCAN && m_ticks == start; i++) @(negedge clock);
        if (m_ticks == start) report_timeout("wait_tick");
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            if (m_slot == s) return;
        end
        report_timeout($sformatf("wait_slot%0d", s));
    endtask

    task automatic apply_stimulus(input logic [23:0] d, input logic [23:0] sd, input logic [1:0] r);
        @(negedge clock);
        data         = d;
        setup_data   = sd;
        setup_rezhim = r;
    endtask

    function automatic logic [7:0] rand_field();
        case ($urandom_range(0, 2))
            0:       return 8'($urandom_range(0, 99));
            1:       return 8'($urandom_range(95, 105));
            default: return 8'($urandom);
        endcase
    endfunction

    typedef struct packed {
        logic [23:0]     data;
        logic [5:0][6:0] segs;
    } vec_t;

    vec_t table_v [6];

    initial begin
        table_v[0] = '{data: 24'h17_3B_2D, segs: {7'h24, 7'h30, 7'h12, 7'h10, 7'h19, 7'h12}};
        table_v[1] = '{data: 24'h0C_22_96, segs: {7'h79, 7'h24, 7'h30, 7'h19, 7'h3F, 7'h3F}};
        table_v[2] = '{data: 24'h00_01_00, segs: {7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40}};
        table_v[3] = '{data: 24'h64_07_09, segs: {7'h3F, 7'h3F, 7'h40, 7'h78, 7'h40, 7'h10}};
        table_v[4] = '{data: 24'h63_63_63, segs: {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10}};
        table_v[5] = '{data: 24'h08_06_01, segs: {7'h40, 7'h00, 7'h40, 7'h02, 7'h40, 7'h79}};

        reset        = 1'b0;
        data         = 24'h17_3B_2D;
        setup_data   = 24'd0;
        setup_rezhim = 2'd0;
        repeat (3) @(negedge clock);
        check_output("reset_state", 7'h7F, 1'b1, 6'h3F);
        reset    = 1'b1;
        check_en = 1;
        repeat (3) @(negedge clock);
        check_output("before_first_tick", 7'h7F, 1'b1, 6'h3F);
        @(negedge clock);
        check_output("first_digit", 7'h12, 1'b1, 6'h3E);

        for (int i = 0; i < 6; i++) begin
            data = table_v[i].data;
            wait_slot(5);
            for (int s = 0; s < 6; s++) begin
                wait_tick();
                check_output($sformatf("table%0d_slot%0d", i, s), table_v[i].segs[s],
                             (s == 2 || s == 4) ? 1'b0 : 1'b1, ~(6'd1 << s));
            end
        end

        // A data change after slot 0 must not tear the frame in progress.
        apply_stimulus(24'h00_00_3B, 24'd0, 2'd0);
        wait_slot(5);
        wait_tick();
        check_output("tear_slot0_old", 7'h10, 1'b1, 6'h3E);
        data = 24'h00_01_00;
        wait_tick();
        check_output("tear_slot1_old", 7'h12, 1'b1, 6'h3D);
        wait_tick();
        check_output("tear_slot2_old", 7'h40, 1'b0, 6'h3B);
        wait_slot(0);
        check_output("tear_slot0_new", 7'h40, 1'b1, 6'h3E);
        wait_tick();
        check_output("tear_slot1_new", 7'h40, 1'b1, 6'h3D);
        wait_tick();
        check_output("tear_slot2_new", 7'h79, 1'b0, 6'h3B);

        // Editing minutes of 05:30:00.
        apply_stimulus(24'h00_01_00, 24'h05_1E_00, 2'd2);
        wait_slot(0);
        wait_slot(2);
        check_output("edit_min_slot2", 7'h40, 1'b0, 6'h3B);
`ifdef TIME_DISPLAY_BLINK_EN
        begin
            int blanked;
            blanked = 0;
            for (int i = 0; i < 3 * BLINK; i++) begin
                @(negedge clock);
                if (dig == 6'h3F) blanked++;
            end
            vectors++;
            if (blanked == 0) begin
                miscompares++;
                $display("[TB] FAIL blink_seen: got %0d blanked cycles, expected nonzero", blanked);
            end
        end
        apply_stimulus(24'h00_01_00, 24'h05_1E_00, 2'd3);
        wait_slot(4);
        check_output("edit_hour_slot4", 7'h12, 1'b0, 6'h2F);
        wait_tick();
        check_output("edit_hour_slot5", 7'h40, 1'b1, 6'h1F);
`else
        wait_tick();
        check_output("edit_min_slot3", 7'h30, 1'b0, 6'h37);
        wait_tick();
        check_output("edit_min_slot4", 7'h12, 1'b0, 6'h2F);
        wait_tick();
        check_output("edit_min_slot5", 7'h40, 1'b1, 6'h1F);
        apply_stimulus(24'h00_01_00, 24'h05_1E_00, 2'd3);
        wait_slot(4);
        check_output("edit_hour_slot4", 7'h12, 1'b0, 6'h2F);
        wait_tick();
        check_output("edit_hour_slot5", 7'h40, 1'b0, 6'h1F);
`endif

        for (int k = 0; k < 60; k++) begin
            apply_stimulus({rand_field(), rand_field(), rand_field()},
                           {rand_field(), rand_field(), rand_field()},
                           ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : setup_rezhim);
            repeat ($urandom_range(1, 40)) @(negedge clock);
        end

        // Asynchronous reset in the middle of a slot.
        apply_stimulus(24'h17_3B_2D, 24'd0, 2'd0);
        repeat (9) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check_output("async_reset", 7'h7F, 1'b1, 6'h3F);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_output("restart_blank", 7'h7F, 1'b1, 6'h3F);
        @(negedge clock);
        check_output("restart_first", 7'h12, 1'b1, 6'h3E);

        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
